// File: rtl/button_conditioner.sv
// Player button front end: synchronize, debounce and edge-detect each GPIO button,
// then latch level and press information once per rendered frame.
module button_conditioner #(
  parameter int unsigned N_BTN           = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 19,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  input  logic             i_render_clk,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_frame_held,
  output logic [N_BTN-1:0] o_frame_press,
  output logic             o_frame_valid
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [N_BTN-1:0]     pressed;
  logic [N_BTN-1:0]     sync1;
  logic [N_BTN-1:0]     sync2;
  logic [N_BTN-1:0]     stable;
  logic [N_BTN-1:0]     toggle;
  logic [N_BTN-1:0]     sticky;
  logic [N_BTN-1:0]     sticky_next;
  logic [CNT_WIDTH-1:0] cnt [N_BTN];
  logic                 render_q;
  logic                 tick;

  assign pressed = ACTIVE_LOW ? ~i_btn : i_btn;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pressed;
      sync2 <= sync1;
    end
  end

  // A toggle needs the count to have reached its last value while still differing.
  always_comb begin
    toggle = '0;
    for (int unsigned b = 0; b < N_BTN; b++) begin
      toggle[b] = (sync2[b] != stable[b]) && (cnt[b] == CNT_LAST);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned b = 0; b < N_BTN; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < N_BTN; b++) begin
        if ((sync2[b] == stable[b]) || toggle[b]) begin
          cnt[b] <= '0;
        end else begin
          cnt[b] <= cnt[b] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stable    <= '0;
      o_press   <= '0;
      o_release <= '0;
    end else begin
      stable    <= stable ^ toggle;
      o_press   <= toggle & ~stable;
      o_release <= toggle & stable;
    end
  end

  assign o_level = stable;

  assign tick        = i_render_clk & ~render_q;
  // Folding o_press in here keeps a press coincident with the tick in the closing frame.
  assign sticky_next = sticky | o_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      render_q      <= 1'b0;
      sticky        <= '0;
      o_frame_held  <= '0;
      o_frame_press <= '0;
      o_frame_valid <= 1'b0;
    end else begin
      render_q      <= i_render_clk;
      o_frame_valid <= tick;
      if (tick) begin
        o_frame_held  <= o_level;
        o_frame_press <= sticky_next;
        sticky        <= '0;
      end else begin
        sticky        <= sticky_next;
      end
    end
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the seven raw player GPIO buttons (right, left, jump, squat, attack, defend, select) before they reach the game controller. Each button is synchronized, debounced and edge-detected. Level and press information is then latched once per rendered frame, so the game logic sees a stable, frame-coherent input snapshot. The block sits between the top-level GPIO pins and `GameControl`, and takes the frame boundary from the VGA `render_clk`.

## Interface
Parameters:
- `N_BTN`, default 7: number of buttons. Bit order: 0 right, 1 left, 2 jump, 3 squat, 4 attack, 5 defend, 6 select.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized cycles required to accept a change (10 ms at 50 MHz). Minimum 2.
- `CNT_WIDTH`, default 19: debounce counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- `ACTIVE_LOW`, default 1: when 1, a raw input of 0 means pressed.

Ports:
- `i_clk` input, 1 bit: system clock.
- `i_rst_n` input, 1 bit: asynchronous active-low reset.
- `i_btn` input, `N_BTN` bits: raw asynchronous button pins.
- `i_render_clk` input, 1 bit: VGA render clock, synchronous to `i_clk`. Its rising edge marks a frame boundary.
- `o_level` output, `N_BTN` bits: debounced level, 1 = pressed.
- `o_press` output, `N_BTN` bits: one-cycle pulse on each debounced press.
- `o_release` output, `N_BTN` bits: one-cycle pulse on each debounced release.
- `o_frame_held` output, `N_BTN` bits: `o_level` sampled at the last frame boundary.
- `o_frame_press` output, `N_BTN` bits: presses that occurred since the previous frame boundary, latched at the boundary.
- `o_frame_valid` output, 1 bit: one-cycle pulse when the frame outputs update.

## Operation
- **Polarity:** raw input is inverted when `ACTIVE_LOW` is 1, giving internal active-high `pressed`.
- **Synchronizer:** each bit passes through a 2-FF synchronizer. Both FFs reset to 0 (released), so no press is seen out of reset.
- **Debounce:** one counter per button, each with a `stable` register.
  - If the synced value equals `stable`: counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1` while still differing, `stable` toggles and the counter clears.
  - Any glitch back to the `stable` value restarts the count.
  - The counter never wraps past `DEBOUNCE_CYCLES-1`.
- **Edge outputs:** `o_level` = `stable`. On a toggle cycle, the registered `o_press` (0→1) or `o_release` (1→0) is high for exactly one cycle, aligned with the new `o_level`.
- **Frame boundary:** `render_q` is a registered copy of `i_render_clk`. `tick = i_render_clk & ~render_q`.
- **Sticky presses:** `sticky_next = sticky | o_press`.
  - On a `tick` cycle: `o_frame_held <= o_level`, `o_frame_press <= sticky_next`, `sticky <= 0`.
  - A press pulse coincident with `tick` therefore lands in the current frame and is not lost or duplicated.
  - Otherwise `sticky <= sticky_next`, and the frame outputs hold.
- **Multiple presses in one frame** collapse to a single `o_frame_press` bit.
- **Independence:** buttons are fully independent. Simultaneous left and right are both reported; arbitration belongs to `GameControl`.

## Timing
- **Reset values:** all outputs, sync FFs, counters, `stable`, `sticky` and `render_q` are 0. Reset mid-debounce discards the count. Reset asserted while a button is held: after release of reset the button is re-accepted as a fresh press after full latency.
- **Press latency:** a clean raw edge reaches `o_level`/`o_press` after 2 sync cycles plus `DEBOUNCE_CYCLES` cycles, ±1 for sampling phase.
- **Frame latency:** `o_frame_held`, `o_frame_press` and `o_frame_valid` update in the cycle after the `i_render_clk` rising edge is sampled. They are stable for the whole following frame.
- **Throughput:** no backpressure; all outputs are free-running.
- **Tick with no activity:** if `tick` occurs before the first press, `o_frame_press` = 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=1.
1. Hold reset, then drive `i_btn`=7'h7F for 20 cycles → `o_level`=0, no press/release pulses, all frame outputs 0.
2. Drive bit 2 low and hold → `o_level[2]`=1 and a single `o_press[2]` pulse about 6 cycles later. Raise bit 2 → a single `o_release[2]` about 6 cycles later.
3. Bounce bit 0 low for 3 cycles, high for 1, low for 3, high → `o_level[0]` stays 0 and no pulses. Then hold low for 6 cycles → one press.
4. Make two full presses of bit 4 inside one `i_render_clk` period, releasing before the edge → after the edge, `o_frame_press[4]`=1, `o_frame_held[4]`=0, one `o_frame_valid` pulse. At the next edge with no activity → `o_frame_press`=0.
5. Align the `o_press[1]` pulse with the `tick` cycle → `o_frame_press[1]`=1 in that frame and 0 in the next.
6. Assert reset for 1 cycle mid-count while bit 6 is held low → outputs clear immediately. `o_press[6]` fires about 6 cycles after reset release.
